// File: rtl/i2s_adc_receiver_if.sv
// i2s_adc_receiver_if: codec-side serial pins plus parallel sample outputs.
// master = codec/stimulus side, slave = receiver side.
interface i2s_adc_receiver_if #(
  parameter int DATA_W = 16
);
  logic              AUD_BCLK;
  logic              AUD_ADCLRCK;
  logic              AUD_ADCDAT;
  logic [DATA_W-1:0] audio_outL;
  logic [DATA_W-1:0] audio_outR;
  logic              sample_valid;
  logic              frame_err;

  modport master (
    output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    input  audio_outL, audio_outR, sample_valid, frame_err
  );

  modport slave (
    input  AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    output audio_outL, audio_outR, sample_valid, frame_err
  );
endinterface

// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver: deserializes the codec ADC I2S stream into left/right
// DATA_W-bit samples, fully in the CLOCK_50 domain (serial pins are
// oversampled through synchronizers). Optional sticky frame error logic is
// built only when I2S_RX_FRAME_ERR_EN is defined.
module i2s_adc_receiver #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 Reset,
  i2s_adc_receiver_if.slave    bus
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_e;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q, dat_sync_q;
  logic                   bclk_d1_q;
  logic                   bclk_s, lrck_s, dat_s;
  logic                   bclk_rise, lrck_edge;
  logic                   lrck_prev_q, prev_ok_q;

  state_e                 state_q, state_d;
  logic                   chan_q;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q;
  logic [DATA_W-1:0]      left_hold_q;
  logic                   left_valid_q;
  logic                   commit_q;
  logic [DATA_W-1:0]      out_l_q, out_r_q;
  logic                   sample_valid_q;

  logic clr_cnt, do_shift, word_done, short_word, latch_left, right_done, inval_left;

  // Synchronizers; no reset so a held-high BCLK cannot fake an edge after Reset.
  always_ff @(posedge CLOCK_50) begin
    bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bus.AUD_BCLK};
    lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], bus.AUD_ADCLRCK};
    dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0],  bus.AUD_ADCDAT};
    bclk_d1_q   <= bclk_s;
  end

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_d1_q;
  // prev_ok_q masks the first rise after reset so a stale lrck_prev
  // cannot report a phantom word-clock edge.
  assign lrck_edge = bclk_rise & prev_ok_q & (lrck_s != lrck_prev_q);
  assign shift_d   = {shift_q[DATA_W-2:0], dat_s};

  // Track the word clock as seen at each bit-clock rise.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      lrck_prev_q <= 1'b0;
      prev_ok_q   <= 1'b0;
    end else if (bclk_rise) begin
      lrck_prev_q <= lrck_s;
      prev_ok_q   <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a word-clock edge wins over bit capture.
  always_comb begin
    state_d = state_q;
    if (lrck_edge) begin
      state_d = SKIP;
    end else if (bclk_rise) begin
      case (state_q)
        SKIP:    state_d = SHIFT;
        SHIFT:   if (bit_cnt_q == CW'(DATA_W-1)) state_d = WAIT;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: datapath strobes.
  always_comb begin
    clr_cnt    = (state_q == SKIP)  & bclk_rise & ~lrck_edge;
    do_shift   = (state_q == SHIFT) & bclk_rise & ~lrck_edge;
    word_done  = do_shift & (bit_cnt_q == CW'(DATA_W-1));
    short_word = (state_q == SHIFT) & lrck_edge;
    latch_left = word_done & ~chan_q;
    right_done = word_done &  chan_q;
    inval_left = lrck_edge & ~lrck_s;
  end

  // Datapath: shifter, left hold, pairing and the delayed commit.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      chan_q         <= 1'b0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      left_hold_q    <= '0;
      left_valid_q   <= 1'b0;
      commit_q       <= 1'b0;
      out_l_q        <= '0;
      out_r_q        <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      commit_q       <= right_done & left_valid_q;
      sample_valid_q <= commit_q;
      if (commit_q) begin
        out_l_q <= left_hold_q;
        out_r_q <= shift_q;
      end
      if (lrck_edge) chan_q <= lrck_s;
      if (clr_cnt)       bit_cnt_q <= '0;
      else if (do_shift) bit_cnt_q <= bit_cnt_q + CW'(1);
      if (do_shift) shift_q <= shift_d;
      if (inval_left) begin
        left_valid_q <= 1'b0;
      end else if (latch_left) begin
        left_hold_q  <= shift_d;
        left_valid_q <= 1'b1;
      end
    end
  end

  assign bus.audio_outL   = out_l_q;
  assign bus.audio_outR   = out_r_q;
  assign bus.sample_valid = sample_valid_q;

`ifdef I2S_RX_FRAME_ERR_EN
  logic err_q, primed_q;

  // Sticky error; unpaired right words only count once a left edge was seen.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      err_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      if (inval_left) primed_q <= 1'b1;
      if (short_word | (right_done & ~left_valid_q & primed_q)) err_q <= 1'b1;
    end
  end

  assign bus.frame_err = err_q;
`else
  logic unused_err;
  assign unused_err    = short_word;
  assign bus.frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver. Slot layout driven per channel:
// rise 0 = word-clock edge detect, rise 1 = dropped delay bit,
// rises 2..DATA_W+1 = sample MSB..LSB, remaining rises = filler.
module tb_i2s_adc_receiver;
  localparam int DATA_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int SLOT        = 32;
`ifdef I2S_RX_FRAME_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic Reset    = 1'b1;

  i2s_adc_receiver_if #(.DATA_W(DATA_W)) bus ();

  i2s_adc_receiver #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          half    = 8;
  int          pulses  = 0;
  int          unstable = 0;
  int          dbl     = 0;
  bit          chk_stable = 1'b0;
  time         t_lsb   = 0;
  time         t_valid = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [DATA_W-1:0] pl = '0, pr = '0;
  logic        psv = 1'b0;

  // Output monitor: pulse count, captured pairs, stability between pulses.
  always @(negedge CLOCK_50) begin
    if (bus.sample_valid) begin
      pulses++;
      got_q.push_back({bus.audio_outL, bus.audio_outR});
      if (!psv) t_valid = $time;
    end
    if (psv && bus.sample_valid) dbl++;
    if (chk_stable && !bus.sample_valid && ({bus.audio_outL, bus.audio_outR} != {pl, pr}))
      unstable++;
    pl  = bus.audio_outL;
    pr  = bus.audio_outR;
    psv = bus.sample_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // One bit period: low phase (LRCK/DAT change at offsets a/b), then high phase.
  task automatic bit_slot(input logic lr, input logic d, input int a, input int b, input bit mark);
    bus.AUD_BCLK = 1'b0;
    for (int k = 0; k < half; k++) begin
      if (k == a) bus.AUD_ADCLRCK = lr;
      if (k == b) bus.AUD_ADCDAT  = d;
      @(negedge CLOCK_50);
    end
    bus.AUD_BCLK = 1'b1;
    if (mark) t_lsb = $time;
    tick(half);
  endtask

  task automatic send_slot(input logic lr, input logic [DATA_W-1:0] w, input int nrise,
                           input logic fill, input bit rnd);
    logic d;
    int   a, b;
    for (int r = 0; r < nrise; r++) begin
      if (r >= 2 && r < DATA_W + 2) d = w[DATA_W + 1 - r];
      else                          d = rnd ? logic'($urandom_range(0, 1)) : fill;
      a = rnd ? int'($urandom_range(0, half - 2)) : 0;
      b = rnd ? int'($urandom_range(0, half - 2)) : 0;
      bit_slot(lr, d, a, b, lr && (r == DATA_W + 1));
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input logic fill, input bit rnd);
    send_slot(1'b0, l, SLOT, fill, rnd);
    send_slot(1'b1, r, SLOT, fill, rnd);
  endtask

  initial begin
    int          base;
    logic [31:0] s2 [3];
    logic [DATA_W-1:0] rl, rr;
    s2[0] = 32'h0001FFFF;
    s2[1] = 32'h1234ABCD;
    s2[2] = 32'h00008000;
    bus.AUD_BCLK    = 1'b0;
    bus.AUD_ADCLRCK = 1'b0;
    bus.AUD_ADCDAT  = 1'b0;

    // Reset state
    tick(5);
    check("rst_outL", 32'(bus.audio_outL), 32'h0);
    check("rst_outR", 32'(bus.audio_outR), 32'h0);
    check("rst_valid", 32'(bus.sample_valid), 32'h0);
    check("rst_err", 32'(bus.frame_err), 32'h0);
    Reset = 1'b0;
    tick(2);
    chk_stable = 1'b1;

    // First frame has no left edge: right word alone must not commit
    send_frame(16'h8001, 16'h7FFE, 1'b1, 1'b0);
    check("first_partial_pulses", 32'(pulses), 32'd0);
    send_frame(16'h8001, 16'h7FFE, 1'b1, 1'b0);
    send_frame(16'h8001, 16'h7FFE, 1'b1, 1'b0);
    check("steady_pulses", 32'(pulses), 32'd2);
    check("steady_pair", {bus.audio_outL, bus.audio_outR}, 32'h80017FFE);
    check("latency_ns", 32'(t_valid - t_lsb), 32'(20 * (SYNC_STAGES + 2)));
    check("no_err_clean", 32'(bus.frame_err), 32'h0);

    // Three distinct frames
    base = pulses;
    got_q.delete();
    send_frame(16'h0001, 16'hFFFF, 1'b1, 1'b0);
    send_frame(16'h1234, 16'hABCD, 1'b0, 1'b0);
    send_frame(16'h0000, 16'h8000, 1'b1, 1'b0);
    check("three_pulses", 32'(pulses - base), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("three_pair%0d", i), (got_q.size() > i) ? got_q[i] : 32'hDEADDEAD, s2[i]);

    // Short left word (10 bits): no commit, error flag in the feature build
    base = pulses;
    send_slot(1'b0, 16'h1111, 12, 1'b1, 1'b0);
    send_slot(1'b1, 16'h7777, SLOT, 1'b1, 1'b0);
    check("short_no_commit", 32'(pulses - base), 32'd0);
    check("short_err", 32'(bus.frame_err), 32'(ERR_EXP));
    send_frame(16'h5555, 16'hAAAA, 1'b0, 1'b0);
    check("after_short_pulses", 32'(pulses - base), 32'd1);
    check("after_short_pair", {bus.audio_outL, bus.audio_outR}, 32'h5555AAAA);

    // Reset mid-right-word
    base = pulses;
    send_slot(1'b0, 16'h2222, SLOT, 1'b1, 1'b0);
    send_slot(1'b1, 16'h3333, 10, 1'b1, 1'b0);
    chk_stable = 1'b0;
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    check("midrst_outL", 32'(bus.audio_outL), 32'h0);
    check("midrst_outR", 32'(bus.audio_outR), 32'h0);
    check("midrst_valid", 32'(bus.sample_valid), 32'h0);
    check("midrst_err", 32'(bus.frame_err), 32'h0);
    tick(2);
    chk_stable = 1'b1;
    send_slot(1'b1, 16'h3333, SLOT - 10, 1'b1, 1'b0);
    check("midrst_ignored", 32'(pulses - base), 32'd0);
    send_frame(16'h2468, 16'h1357, 1'b0, 1'b0);
    check("midrst_commit_pulses", 32'(pulses - base), 32'd1);
    check("midrst_pair", {bus.audio_outL, bus.audio_outR}, 32'h24681357);
    check("midrst_no_err", 32'(bus.frame_err), 32'h0);

    // Filler ones after the sample bits must be ignored
    send_frame(16'h00F0, 16'h00F0, 1'b1, 1'b0);
    check("filler_pair", {bus.audio_outL, bus.audio_outR}, 32'h00F000F0);

    // Fastest bit clock, random skew and filler, 100 frames
    half = 3;
    base = pulses;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 100; i++) begin
      rl = DATA_W'($urandom);
      rr = DATA_W'($urandom);
      exp_q.push_back({rl, rr});
      send_frame(rl, rr, 1'b0, 1'b1);
    end
    check("rand_pulses", 32'(pulses - base), 32'd100);
    for (int i = 0; i < 100; i++)
      check($sformatf("rand_pair%0d", i), (got_q.size() > i) ? got_q[i] : 32'hDEADDEAD, exp_q[i]);

    check("stable_between_pulses", 32'(unstable), 32'd0);
    check("single_cycle_pulse", 32'(dbl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_adc_receiver.md
Name: i2s_adc_receiver

Overview:
- Upstream stage of the audio effect chain: deserializes the codec ADC I2S stream into 16-bit left/right parallel samples.
- Feeds audio_inL/audio_inR of the low-pass filter and other effect stages.
- Codec serial clocks are asynchronous to CLOCK_50. They are synchronized, edge-detected and decoded entirely in the CLOCK_50 domain.

Parameters:
- DATA_W, 16: bits captured per channel (MSB first); remaining slot bits are ignored.
- SYNC_STAGES, 2: flip-flop synchronizer depth on AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT (minimum 2).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz; the only clock in the block.
- Reset  input  1  synchronous, active-high reset.
- AUD_BCLK  input  1  codec bit clock (async, at most CLOCK_50/6).
- AUD_ADCLRCK  input  1  codec ADC word clock (async); 0 = left, 1 = right.
- AUD_ADCDAT  input  1  codec ADC serial data (async).
- audio_outL  output  DATA_W  last complete left sample, two's complement.
- audio_outR  output  DATA_W  last complete right sample, two's complement.
- sample_valid  output  1  one-cycle pulse when audio_outL/R update.
- frame_err  output  1  sticky short-word error flag (see Optional Feature).

Behaviour:
- Sync: each async input passes through SYNC_STAGES flops, plus one extra flop of BCLK for edge detect.
- bclk_rise = 1 for exactly one CLOCK_50 cycle per BCLK rising edge. All LRCK and data sampling happens only on bclk_rise.
- lrck_prev is a register updated on every bclk_rise. lrck_edge = (sync LRCK != lrck_prev) at a bclk_rise.
- FSM states: IDLE, SKIP, SHIFT, WAIT.
  - IDLE: after reset. Ignore data until lrck_edge, then go to SKIP. chan is loaded with the new LRCK value.
  - SKIP: I2S one-bit delay. The next bclk_rise is discarded; go to SHIFT with bit_cnt = 0.
  - SHIFT: each bclk_rise does shift_reg = {shift_reg[DATA_W-2:0], ADCDAT_sync} and bit_cnt++.
    - At bit_cnt = DATA_W-1, the word is complete. chan = 0: latch into left_hold. chan = 1: commit (below). Go to WAIT.
  - WAIT: ignore bits until lrck_edge, then go to SKIP with chan updated.
- lrck_edge while in SHIFT (word shorter than DATA_W): discard the partial word, go to SKIP for the new channel, set the error condition. No commit.
- lrck_edge has priority over bit capture in the same bclk_rise cycle.
- Commit: on the CLOCK_50 cycle after the final right bit is shifted:
  - audio_outL <= left_hold, audio_outR <= shift result.
  - sample_valid = 1 for that cycle only.
- Latency: pin-level right LSB rising edge to sample_valid is SYNC_STAGES+2 CLOCK_50 cycles.
- Pairing rule: a right word commits only if a left word completed earlier in the same frame.
  - A right word with no preceding left word in that frame (first frame after reset, or left word was short) produces no commit.
  - left_hold is invalidated at every left lrck_edge.
- Outputs hold their values between commits. The filter samples them on its own AUD_DACLRCK and tolerates the update at any time.
- Reset (any cycle, including mid-word): all outputs 0, shift_reg/bit_cnt/left_hold cleared, left_valid 0, FSM to IDLE. A fresh LRCK edge is required before the next capture.
- No overflow path: a new frame always overwrites. Consumers needing every sample must use sample_valid.

Optional Feature:
- Macro: I2S_RX_FRAME_ERR_EN.
- Defined: frame_err is set by a short word (lrck_edge in SHIFT) or by a right commit attempted without a valid left word after the first full frame. It stays set until Reset.
- Not defined: frame_err tied to 0 and the error logic is not synthesized. Data-path behaviour is identical in both builds.

Test Plan:
- BCLK 3.072 MHz, 32-bit slots, left = 16'h8001, right = 16'h7FFE: after the first full frame, audio_outL = 8001, audio_outR = 7FFE, one sample_valid pulse per frame, none during the first partial frame.
- Three consecutive frames L/R = 0001/FFFF, 1234/ABCD, 0000/8000: exactly three pulses; each output pair matches its frame and is stable between pulses.
- LRCK toggles after 10 left bits: no commit for that frame, next full frame commits correctly. frame_err = 1 with I2S_RX_FRAME_ERR_EN, 0 without.
- Reset asserted for 1 cycle mid-right-word: outputs 0, sample_valid 0. The next frame is ignored until an LRCK edge; first commit is on the following complete frame.
- Data bits 17–32 of each slot driven as 1s with sample 16'h00F0: outputs exactly 00F0, extra bits ignored.
- BCLK = CLOCK_50/6 with random skew between LRCK and DAT: no missed edges; 100 random frames match the reference model.
